// File: rtl/cpu_trace_monitor_pkg.sv
// Shared types and helpers for the CPU trace monitor.
//   state_e : capture controller states
//   idx_w() : width of a channel index, never less than one bit
package cpu_trace_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_trace_monitor_fifo.sv
// First-word-fall-through FIFO holding trace entries.
//   clk_i, rst_ni      : clock, async active-low reset (discards contents)
//   push_i, wdata_i    : write request and entry
//   pop_i              : consume head (ignored when empty)
//   full_o, empty_o    : occupancy flags
//   rdata_o            : head entry, zero while empty
// A push while full is accepted only if a pop happens in the same cycle.
module cpu_trace_monitor_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    assign wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Capture block between a CPU top and its harness. Samples NUM_CH
// (valid, data) channels, stamps accepted samples with the RUN cycle
// count and queues them for a valid/ready consumer.
//   clk_i, rst_ni            : clock, async active-low reset
//   halt_i                   : CPU halt request (level)
//   in_valid_i, in_data_i    : channel c data at [c*DATA_W +: DATA_W]
//   out_valid_o/out_ready_i  : head handshake
//   out_data_o/out_ch_o/out_cycle_o : head entry fields
//   cycle_count_o            : cycles spent in RUN (saturating)
//   drop_count_o             : samples lost, any cause (saturating)
//   overflow_o, timeout_o, done_o   : sticky status
//
// state    | meaning
// ST_RUN   | capturing, cycle counter running, watchdog armed
// ST_DRAIN | capture off, waiting for consumer to empty the FIFO
// ST_DONE  | shutdown complete, held until reset
module cpu_trace_monitor
    import cpu_trace_monitor_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int NUM_CH  = 1,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 32,
    localparam int CH_W   = idx_w(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     halt_i,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [CH_W-1:0]          out_ch_o,
    output logic [CNT_W-1:0]         out_cycle_o,
    output logic [CNT_W-1:0]         cycle_count_o,
    output logic [CNT_W-1:0]         drop_count_o,
    output logic                     overflow_o,
    output logic                     timeout_o,
    output logic                     done_o
);

    localparam int  EW    = CH_W + CNT_W + DATA_W;
    localparam bit  WD_EN = (TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CH_W-1:0]  rr_q, rr_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;

    logic             grant;
    logic [CH_W-1:0]  grant_ch;
    logic [DATA_W-1:0] grant_data;
    logic [CNT_W-1:0] n_valid;
    logic [CNT_W-1:0] drop_inc;
    logic [CNT_W:0]   drop_sum;
    logic             run;
    logic             timeout_hit;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_drop;
    logic [EW-1:0]    fifo_wdata, fifo_rdata;

    // Round-robin: first valid channel at or above the pointer wins,
    // otherwise the first valid channel below it.
    always_comb begin
        grant      = 1'b0;
        grant_ch   = '0;
        grant_data = '0;
        n_valid    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            n_valid = n_valid + CNT_W'(in_valid_i[c]);
            if (!grant && in_valid_i[c] && (c >= int'(rr_q))) begin
                grant      = 1'b1;
                grant_ch   = CH_W'(c);
                grant_data = in_data_i[c*DATA_W +: DATA_W];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!grant && in_valid_i[c] && (c < int'(rr_q))) begin
                grant      = 1'b1;
                grant_ch   = CH_W'(c);
                grant_data = in_data_i[c*DATA_W +: DATA_W];
            end
        end
    end

    assign run         = (state_q == ST_RUN);
    assign timeout_hit = WD_EN && (cycle_q == CNT_W'(TIMEOUT - 1));
    assign fifo_pop    = out_ready_i && !fifo_empty;
    assign fifo_push   = run && grant;
    assign fifo_drop   = fifo_push && fifo_full && !fifo_pop;
    assign fifo_wdata  = {grant_ch, cycle_q, grant_data};

    cpu_trace_monitor_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (fifo_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        drop_d     = drop_q;
        rr_d       = rr_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        drop_inc   = '0;
        drop_sum   = '0;
        case (state_q)
            ST_RUN: begin
                cycle_d  = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
                // Arbitration losers plus a granted sample rejected by a full FIFO.
                drop_inc = n_valid - CNT_W'(grant) + CNT_W'(fifo_drop);
                drop_sum = {1'b0, drop_q} + {1'b0, drop_inc};
                drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
                if (fifo_drop) begin
                    overflow_d = 1'b1;
                end
                if (grant) begin
                    rr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
                end
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DRAIN;
                end
                if (halt_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            cycle_q    <= '0;
            drop_q     <= '0;
            rr_q       <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            drop_q     <= drop_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    assign out_valid_o   = !fifo_empty;
    assign out_data_o    = fifo_rdata[DATA_W-1:0];
    assign out_cycle_o   = fifo_rdata[DATA_W +: CNT_W];
    assign out_ch_o      = fifo_rdata[DATA_W+CNT_W +: CH_W];
    assign cycle_count_o = cycle_q;
    assign drop_count_o  = drop_q;
    assign overflow_o    = overflow_q;
    assign timeout_o     = timeout_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
module tb_cpu_trace_monitor;

    localparam int DW   = 16;
    localparam int NCH  = 3;
    localparam int DEP  = 4;
    localparam int TO   = 40;
    localparam int CW   = 16;
    localparam int CHW  = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              halt = 1'b0;
    logic              out_ready = 1'b0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH*DW-1:0] in_data = '0;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
    logic [CW-1:0]     out_cycle, cycle_count, drop_count;
    logic              overflow, timeout, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int            ch;
        int            cyc;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model: queue of entries plus counters; mst 0=run 1=drain 2=done
    ent_t mq[$];
    int   mst, mcyc, mdrop, mrr;
    bit   movf, mto;

    always #5 clk = ~clk;

    cpu_trace_monitor #(
        .DATA_W (DW), .NUM_CH (NCH), .DEPTH (DEP), .TIMEOUT (TO), .CNT_W (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .halt_i        (halt),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_ch_o      (out_ch),
        .out_cycle_o   (out_cycle),
        .cycle_count_o (cycle_count),
        .drop_count_o  (drop_count),
        .overflow_o    (overflow),
        .timeout_o     (timeout),
        .done_o        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("out_data", out_data, mq[0].data);
            check("out_ch", out_ch, mq[0].ch);
            check("out_cycle", out_cycle, mq[0].cyc);
        end
        check("cycle_count", cycle_count, mcyc);
        check("drop_count", drop_count, mdrop);
        check("overflow", overflow, movf);
        check("timeout", timeout, mto);
        check("done", done, mst == 2);
    endtask

    // Apply one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input logic h, input logic [NCH-1:0] v, input logic r,
                        input logic [NCH*DW-1:0] d);
        int   granted, nv, drops, c;
        bit   pop, push;
        ent_t e;
        halt      = h;
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        pop  = r && (mq.size() > 0);
        push = 1'b0;
        e    = '{ch: 0, cyc: 0, data: '0};
        if (mst == 0) begin
            nv = 0;
            granted = -1;
            for (int k = 0; k < NCH; k++) begin
                if (v[k]) nv++;
                c = (mrr + k) % NCH;
                if (granted < 0 && v[c[CHW-1:0]]) granted = c;
            end
            drops = nv - ((granted >= 0) ? 1 : 0);
            if (granted >= 0) begin
                mrr = (granted + 1) % NCH;
                if (mq.size() == DEP && !pop) begin
                    drops++;
                    movf = 1'b1;
                end else begin
                    push   = 1'b1;
                    e.ch   = granted;
                    e.cyc  = mcyc;
                    e.data = d[granted*DW +: DW];
                end
            end
            mdrop = (mdrop + drops > MAXC) ? MAXC : mdrop + drops;
            if (mcyc == TO - 1) begin
                mto = 1'b1;
                mst = 1;
            end
            if (h) mst = 1;
            if (mcyc < MAXC) mcyc++;
        end else if (mst == 1) begin
            if (mq.size() == 0) mst = 2;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge; asserts reset asynchronously and checks before the next rising edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        halt      = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        mq.delete();
        mst = 0; mcyc = 0; mdrop = 0; mrr = 0; movf = 1'b0; mto = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_ch", out_ch, '0);
        check("rst_out_cycle", out_cycle, '0);
        check("rst_cycle_count", cycle_count, '0);
        check("rst_drop_count", drop_count, '0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int               exp2 [4];
        int               n;
        logic [NCH-1:0]   v;
        logic [63:0]      r64;
        logic             hr, rr;

        @(negedge clk);

        // Single channel samples at RUN cycles 3 and 5
        do_reset();
        repeat (3) step(1'b0, 3'b000, 1'b1, '0);
        step(1'b0, 3'b001, 1'b1, 48'h000A);
        check("t1_head_a", out_data, 16'h000A);
        check("t1_stamp_a", out_cycle, 16'd3);
        step(1'b0, 3'b000, 1'b1, '0);
        step(1'b0, 3'b001, 1'b1, 48'h000B);
        check("t1_head_b", out_data, 16'h000B);
        check("t1_stamp_b", out_cycle, 16'd5);
        check("t1_drops", drop_count, 16'd0);

        // Two channels contending for four cycles
        do_reset();
        exp2 = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b011, 1'b1, {16'h0012, 16'h0011, 16'h0010});
            check("t2_grant_ch", out_ch, exp2[i]);
            check("t2_grant_data", out_data, 16'h0010 + exp2[i]);
        end
        check("t2_drops", drop_count, 16'd4);
        step(1'b0, 3'b000, 1'b1, '0);

        // Overflow, then push accepted while full because of a pop
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 3'b001, 1'b0, 48'(16'h0020 + i));
        check("t3_drops", drop_count, 16'd2);
        check("t3_overflow", overflow, 1'b1);
        check("t3_head", out_data, 16'h0020);
        step(1'b0, 3'b001, 1'b1, 48'h0026);
        check("t3_full_pop_drops", drop_count, 16'd2);
        check("t3_full_pop_head", out_data, 16'h0021);

        // Halt with queued samples, drain, then done
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 3'b001, 1'b0, 48'(16'h0030 + i));
        step(1'b1, 3'b000, 1'b0, '0);
        step(1'b0, 3'b000, 1'b0, '0);
        check("t4_drain_done", done, 1'b0);
        check("t4_drain_valid", out_valid, 1'b1);
        repeat (3) step(1'b0, 3'b000, 1'b1, '0);
        check("t4_empty_valid", out_valid, 1'b0);
        check("t4_empty_done", done, 1'b0);
        step(1'b0, 3'b000, 1'b1, '0);
        check("t4_done", done, 1'b1);

        // Watchdog
        do_reset();
        repeat (TO - 1) step(1'b0, 3'b000, 1'b1, '0);
        check("t5_pre_cycle", cycle_count, 16'(TO - 1));
        check("t5_pre_timeout", timeout, 1'b0);
        step(1'b0, 3'b000, 1'b1, '0);
        check("t5_timeout", timeout, 1'b1);
        check("t5_cycle", cycle_count, 16'(TO));
        step(1'b0, 3'b000, 1'b1, '0);
        check("t5_done", done, 1'b1);
        step(1'b0, 3'b000, 1'b1, '0);
        check("t5_frozen", cycle_count, 16'(TO));

        // Async reset mid-drain with a non-empty FIFO and overflow set
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 3'b001, 1'b0, 48'(16'h0040 + i));
        step(1'b1, 3'b000, 1'b0, '0);
        check("t6_pre_overflow", overflow, 1'b1);
        do_reset();

        // Randomized phases against the model
        for (int p = 0; p < 8; p++) begin
            do_reset();
            n = $urandom_range(35, 15);
            for (int i = 0; i < n; i++) begin
                v   = NCH'($urandom_range(7, 0));
                r64 = {$urandom, $urandom};
                hr  = ($urandom_range(39, 0) == 0);
                rr  = ($urandom_range(1, 0) == 1);
                step(hr, v, rr, r64[NCH*DW-1:0]);
            end
            repeat (DEP + 3) step(1'b1, 3'b000, 1'b1, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
